// File: rtl/quad_updown_decoder_pkg.sv
// Shared types and helpers for the quadrature up/down decoder.
// Gray-code constants follow the "A leads" (count-up) order.
package quad_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MV_NONE    = 2'b00,
    MV_UP      = 2'b01,
    MV_DOWN    = 2'b10,
    MV_ILLEGAL = 2'b11
  } move_e;

  // {A, B} phase pairs in counting-up order
  localparam logic [1:0] GRAY_0 = 2'b00;
  localparam logic [1:0] GRAY_1 = 2'b10;
  localparam logic [1:0] GRAY_2 = 2'b11;
  localparam logic [1:0] GRAY_3 = 2'b01;

  function automatic move_e decode_move(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] up_next;
    move_e      mv;
    case (prev)
      GRAY_0:  up_next = GRAY_1;
      GRAY_1:  up_next = GRAY_2;
      GRAY_2:  up_next = GRAY_3;
      GRAY_3:  up_next = GRAY_0;
      default: up_next = GRAY_1;
    endcase
    if (prev == cur) begin
      mv = MV_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      mv = MV_ILLEGAL;
    end else if (cur == up_next) begin
      mv = MV_UP;
    end else begin
      mv = MV_DOWN;
    end
    return mv;
  endfunction

endpackage

// File: rtl/quad_updown_decoder_if.sv
// Encoder-side inputs and decoded-position outputs of the decoder.
// master drives the encoder phases and controls; slave is the decoder.
interface quad_updown_decoder_if #(
  parameter int CNT_W = 4
);
  logic             enc_a;
  logic             enc_b;
  logic             clr;
  logic             err_clr;
  logic             step;
  logic             dir;
  logic [CNT_W-1:0] pos;
  logic             err;

  modport master (
    output enc_a, enc_b, clr, err_clr,
    input  step, dir, pos, err
  );

  modport slave (
    input  enc_a, enc_b, clr, err_clr,
    output step, dir, pos, err
  );
endinterface

// File: rtl/quad_glitch_filter.sv
// Two-flop synchroniser plus stable-count glitch filter for one encoder phase.
// load snaps the filtered output to the synchronised value with no qualification.
module quad_glitch_filter #(
  parameter int FILT_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic d,
  output logic q,
  output logic sync
);

  localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic            s1_q;
  logic            s2_q;
  logic            filt_q;
  logic            filt_d;
  logic [FC_W-1:0] fc_q;
  logic [FC_W-1:0] fc_d;

  // Filter next state: s2 must differ from filt for FILT_LEN edges in a row
  always_comb begin
    filt_d = filt_q;
    fc_d   = fc_q;
    if (load) begin
      filt_d = s2_q;
      fc_d   = FC_W'(0);
    end else if (s2_q == filt_q) begin
      fc_d   = FC_W'(0);
    end else if (fc_q == FC_W'(FILT_LEN - 1)) begin
      filt_d = s2_q;
      fc_d   = FC_W'(0);
    end else begin
      fc_d   = fc_q + FC_W'(1);
    end
  end

  // Synchroniser and filter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      fc_q   <= FC_W'(0);
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      fc_q   <= fc_d;
    end
  end

  assign q    = filt_q;
  assign sync = s2_q;

endmodule

// File: rtl/quad_updown_decoder.sv
// Quadrature decoder: filters A/B, emits step/dir pulses and a wrapping position.
// Illegal double-bit transitions latch a sticky error until err_clr.
module quad_updown_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int FILT_LEN = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  quad_updown_decoder_if.slave      bus
);

  localparam int INIT_LAST = FILT_LEN + 1;
  localparam int INIT_W    = $clog2(INIT_LAST + 1);

  state_e           state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [1:0]       prev_q, prev_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             err_q, err_d;

  logic  load_s;
  logic  filt_a_s, filt_b_s;
  logic  sync_a_s, sync_b_s;
  logic [1:0] cur_s;
  move_e move_s;

  quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .d    (bus.enc_a),
    .q    (filt_a_s),
    .sync (sync_a_s)
  );

  quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .d    (bus.enc_b),
    .q    (filt_b_s),
    .sync (sync_b_s)
  );

  assign cur_s  = {filt_a_s, filt_b_s};
  assign move_s = decode_move(prev_q, cur_s);

  // Next state and output decode; INIT waits out sync+filter latency before trusting phases
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = prev_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    pos_d      = pos_q;
    err_d      = err_q;
    load_s     = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_W'(INIT_LAST)) begin
          load_s     = 1'b1;
          prev_d     = {sync_a_s, sync_b_s};
          init_cnt_d = INIT_W'(0);
          state_d    = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      ST_RUN: begin
        prev_d = cur_s;
        case (move_s)
          MV_UP: begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            pos_d  = pos_q + CNT_W'(1);
          end
          MV_DOWN: begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            pos_d  = pos_q - CNT_W'(1);
          end
          MV_ILLEGAL: begin
            err_d = 1'b1;
          end
          default: begin
            step_d = 1'b0;
          end
        endcase
        // clr overrides the count but the step itself is still reported
        if (bus.clr) begin
          pos_d = CNT_W'(0);
        end else begin
          pos_d = pos_d;
        end
        if (bus.err_clr && (move_s != MV_ILLEGAL)) begin
          err_d = 1'b0;
        end else begin
          err_d = err_d;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = INIT_W'(0);
      end
    endcase
  end

  // State and registered-output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= INIT_W'(0);
      prev_q     <= 2'b00;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      pos_q      <= CNT_W'(0);
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      pos_q      <= pos_d;
      err_q      <= err_d;
    end
  end

  assign bus.step = step_q;
  assign bus.dir  = dir_q;
  assign bus.pos  = pos_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_updown_decoder.sv
// Directed bench for quad_updown_decoder (CNT_W=4, FILT_LEN=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_quad_updown_decoder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  quad_updown_decoder_if #(.CNT_W(4)) bus ();

  quad_updown_decoder #(.CNT_W(4), .FILT_LEN(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic a, input logic b);
    bus.enc_a = a;
    bus.enc_b = b;
  endtask

  // One legal quarter-step held for 8 clocks; step expected 5 cycles after drive
  task automatic move(input logic a, input logic b, input logic exp_dir, input logic [3:0] exp_pos);
    set_ab(a, b);
    repeat (4) cyc();
    check_eq("step_early", 32'(bus.step), 32'd0);
    cyc();
    check_eq("step", 32'(bus.step), 32'd1);
    check_eq("dir", 32'(bus.dir), 32'(exp_dir));
    check_eq("pos", 32'(bus.pos), 32'(exp_pos));
    cyc();
    check_eq("step_once", 32'(bus.step), 32'd0);
    repeat (2) cyc();
  endtask

  // Watch n cycles, recording any step or err activity
  task automatic quiet(input int n, output logic saw_step, output logic saw_err);
    saw_step = 1'b0;
    saw_err  = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc();
      saw_step |= bus.step;
      saw_err  |= bus.err;
    end
  endtask

  initial begin
    logic s_step;
    logic s_err;
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    bus.clr     = 1'b0;
    bus.err_clr = 1'b0;
    set_ab(1'b0, 1'b0);
    repeat (3) cyc();
    check_eq("rst_step", 32'(bus.step), 32'd0);
    check_eq("rst_dir", 32'(bus.dir), 32'd0);
    check_eq("rst_pos", 32'(bus.pos), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    repeat (8) cyc();

    // 1: four up quarter-steps
    move(1'b1, 1'b0, 1'b1, 4'd1);
    move(1'b1, 1'b1, 1'b1, 4'd2);
    move(1'b0, 1'b1, 1'b1, 4'd3);
    move(1'b0, 1'b0, 1'b1, 4'd4);

    // 2: five down quarter-steps, wrapping below zero
    move(1'b0, 1'b1, 1'b0, 4'd3);
    move(1'b1, 1'b1, 1'b0, 4'd2);
    move(1'b1, 1'b0, 1'b0, 4'd1);
    move(1'b0, 1'b0, 1'b0, 4'd0);
    move(1'b0, 1'b1, 1'b0, 4'd15);
    move(1'b0, 1'b0, 1'b1, 4'd0);

    // 3: 1-clk glitch on A is rejected
    set_ab(1'b1, 1'b0);
    cyc();
    set_ab(1'b0, 1'b0);
    quiet(10, s_step, s_err);
    check_eq("glitch_step", 32'(s_step), 32'd0);
    check_eq("glitch_pos", 32'(bus.pos), 32'd0);
    check_eq("glitch_err", 32'(s_err), 32'd0);

    // 3b: 2-clk pulse on A passes: up step then down step
    set_ab(1'b1, 1'b0);
    repeat (2) cyc();
    set_ab(1'b0, 1'b0);
    repeat (3) cyc();
    check_eq("pulse_up_step", 32'(bus.step), 32'd1);
    check_eq("pulse_up_dir", 32'(bus.dir), 32'd1);
    check_eq("pulse_up_pos", 32'(bus.pos), 32'd1);
    cyc();
    check_eq("pulse_gap", 32'(bus.step), 32'd0);
    cyc();
    check_eq("pulse_dn_step", 32'(bus.step), 32'd1);
    check_eq("pulse_dn_dir", 32'(bus.dir), 32'd0);
    check_eq("pulse_dn_pos", 32'(bus.pos), 32'd0);
    repeat (4) cyc();

    // 4: illegal 00->11, err_clr, then err_clr racing a new illegal jump
    set_ab(1'b1, 1'b1);
    repeat (4) cyc();
    check_eq("ill_err_early", 32'(bus.err), 32'd0);
    cyc();
    check_eq("ill_err", 32'(bus.err), 32'd1);
    check_eq("ill_step", 32'(bus.step), 32'd0);
    check_eq("ill_pos", 32'(bus.pos), 32'd0);
    check_eq("ill_dir", 32'(bus.dir), 32'd0);
    repeat (3) cyc();
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
    check_eq("errclr", 32'(bus.err), 32'd0);
    set_ab(1'b0, 1'b0);
    repeat (4) cyc();
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
    check_eq("set_wins_err", 32'(bus.err), 32'd1);
    check_eq("set_wins_step", 32'(bus.step), 32'd0);
    cyc();
    check_eq("set_wins_hold", 32'(bus.err), 32'd1);

    // 5: reset with A=B=1 -> silent INIT, then 11->01 counts up
    rst = 1'b1;
    set_ab(1'b1, 1'b1);
    repeat (3) cyc();
    rst = 1'b0;
    quiet(10, s_step, s_err);
    check_eq("init11_step", 32'(s_step), 32'd0);
    check_eq("init11_err", 32'(s_err), 32'd0);
    check_eq("init11_pos", 32'(bus.pos), 32'd0);
    move(1'b0, 1'b1, 1'b1, 4'd1);

    // 6: climb to 7, then clr coincident with an up step
    move(1'b0, 1'b0, 1'b1, 4'd2);
    move(1'b1, 1'b0, 1'b1, 4'd3);
    move(1'b1, 1'b1, 1'b1, 4'd4);
    move(1'b0, 1'b1, 1'b1, 4'd5);
    move(1'b0, 1'b0, 1'b1, 4'd6);
    move(1'b1, 1'b0, 1'b1, 4'd7);
    set_ab(1'b1, 1'b1);
    repeat (4) cyc();
    bus.clr = 1'b1;
    cyc();
    bus.clr = 1'b0;
    check_eq("clr_pos", 32'(bus.pos), 32'd0);
    check_eq("clr_step", 32'(bus.step), 32'd1);
    check_eq("clr_dir", 32'(bus.dir), 32'd1);
    repeat (3) cyc();
    move(1'b0, 1'b1, 1'b1, 4'd1);

    // 6b: set err, then reset mid-move clears everything and re-enters INIT
    set_ab(1'b1, 1'b0);
    repeat (5) cyc();
    check_eq("pre_rst_err", 32'(bus.err), 32'd1);
    check_eq("pre_rst_pos", 32'(bus.pos), 32'd1);
    set_ab(1'b0, 1'b0);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_eq("mid_rst_pos", 32'(bus.pos), 32'd0);
    check_eq("mid_rst_err", 32'(bus.err), 32'd0);
    check_eq("mid_rst_step", 32'(bus.step), 32'd0);
    quiet(10, s_step, s_err);
    check_eq("reinit_step", 32'(s_step), 32'd0);
    check_eq("reinit_err", 32'(s_err), 32'd0);
    move(1'b1, 1'b0, 1'b1, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
